mem_stage_req: RTL and testbench

// - Consumer end of the MP pipeline latch: reads the latched memory-stage fields and issues D-cache accesses.
// - Splits line-crossing (spill) accesses into two cache requests and merges the returned data.
// - Drives stall back to the MP latch while an access is in flight.
// - Presents one completed op per instruction to the next stage.

---
 rtl/mem_stage_req_if.sv | 34 +++
 rtl/mem_stage_req.sv | 77 +++++++
 tb/tb_mem_stage_req.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_req_if.sv
// mem_stage_req_if: MP-latch fields, D-cache request/response and next-stage result of the memory request stage.
interface mem_stage_req_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
);
  logic              v;
  logic              rd;
  logic              wr;
  logic              cachable;
  logic [ADDR_W-1:0] phys_addr;
  logic [1:0]        req_size;
  logic              spill;
  logic [DATA_W-1:0] wdata;
  logic              flush;
  logic              stall;
  logic              dc_req;
  logic [ADDR_W-1:0] dc_addr;
  logic [1:0]        dc_size;
  logic              dc_wr;
  logic              dc_uc;
  logic [DATA_W-1:0] dc_wdata;
  logic              dc_ack;
  logic [DATA_W-1:0] dc_rdata;
  logic              v_out;
  logic [DATA_W-1:0] rdata;
  modport slave (
    input  v, rd, wr, cachable, phys_addr, req_size, spill, wdata, flush, dc_ack, dc_rdata,
    output stall, dc_req, dc_addr, dc_size, dc_wr, dc_uc, dc_wdata, v_out, rdata
  );
  modport master (
    output v, rd, wr, cachable, phys_addr, req_size, spill, wdata, flush, dc_ack, dc_rdata,
    input  stall, dc_req, dc_addr, dc_size, dc_wr, dc_uc, dc_wdata, v_out, rdata
  );
endinterface

// File: rtl/mem_stage_req.sv
// mem_stage_req: issues D-cache accesses for the latched MP op, splitting line-crossing accesses and merging load data.
module mem_stage_req #(
  parameter int ADDR_W     = 15,
  parameter int LINE_OFF_W = 4,
  parameter int DATA_W     = 32
) (
  input logic            clk,
  input logic            rst,
  mem_stage_req_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ1, REQ2, DONE} state_t;
  localparam logic [LINE_OFF_W:0] LINE_B = (LINE_OFF_W+1)'(1) << LINE_OFF_W;
  state_t                         state;
  logic                           kill;
  logic [DATA_W-1:0]              merge;
  logic                           mem;
  logic                           req;
  logic [2:0]                     nb;
  logic [2:0]                     n1;
  logic [2:0]                     n2;
  logic [5:0]                     sh;
  logic [DATA_W-1:0]              mask1;
  logic [ADDR_W-LINE_OFF_W-1:0]   line_nx;
  // n1 is the byte count of the first piece; a legal spill leaves at most 3 bytes before the line end
  always_comb begin
    mem     = bus.v & (bus.rd | bus.wr);
    req     = state == REQ1 || state == REQ2;
    nb      = {1'b0, bus.req_size} + 3'd1;
    n1      = bus.spill ? 3'(LINE_B - {1'b0, bus.phys_addr[LINE_OFF_W-1:0]}) : nb;
    n2      = nb - n1;
    sh      = {n1, 3'b000};
    mask1   = ~({DATA_W{1'b1}} << sh);
    line_nx = bus.phys_addr[ADDR_W-1:LINE_OFF_W] + (ADDR_W-LINE_OFF_W)'(1);
    bus.stall    = (state == IDLE && mem && !bus.flush) || req;
    bus.v_out    = (state == IDLE && bus.v && !mem && !bus.flush) || (state == DONE && !kill && !bus.flush);
    bus.dc_req   = req;
    bus.dc_wr    = req & bus.wr;
    bus.dc_uc    = !bus.cachable;
    bus.dc_addr  = state == REQ2 ? {line_nx, {LINE_OFF_W{1'b0}}} : bus.phys_addr;
    bus.dc_size  = state == REQ2 ? 2'(n2 - 3'd1) : 2'(n1 - 3'd1);
    bus.dc_wdata = state == REQ2 ? bus.wdata >> sh : bus.wdata;
    bus.rdata    = merge;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      kill  <= 1'b0;
      merge <= '0;
    end else begin
      case (state)
        IDLE: if (mem && !bus.flush) begin
          state <= REQ1;
          kill  <= 1'b0;
          merge <= '0;
        end
        REQ1: begin
          if (bus.flush) kill <= 1'b1;
          if (bus.dc_ack) begin
            if (bus.rd) merge <= bus.dc_rdata & mask1;
            state <= (bus.spill && !kill && !bus.flush) ? REQ2 : DONE;
          end
        end
        REQ2: begin
          if (bus.flush) kill <= 1'b1;
          if (bus.dc_ack) begin
            if (bus.rd) merge <= merge | (bus.dc_rdata << sh);
            state <= DONE;
          end
        end
        default: begin
          state <= IDLE;
          kill  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage_req.sv
// tb_mem_stage_req: scoreboard bench for mem_stage_req with a delay-programmable D-cache responder.
module tb_mem_stage_req;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  mem_stage_req_if bus();
  mem_stage_req dut (.clk(clk), .rst(rst), .bus(bus.slave));
  typedef struct {logic [14:0] addr; logic [1:0] size; logic wr; logic [31:0] wdata;} req_t;
  typedef struct {logic chk; logic [31:0] rdata;} out_t;
  req_t        exp_req[$];
  out_t        exp_out[$];
  logic [31:0] rq[$];
  req_t        me;
  out_t        mo;
  logic [31:0] mm;
  int checks = 0, failures = 0, ack_delay = 0, wait_cnt = 0;
  initial begin
    bus.dc_ack = 0;
    bus.dc_rdata = 0;
    forever begin
      @(posedge clk);
      #2;
      if (bus.dc_req && wait_cnt >= ack_delay) begin
        bus.dc_ack = 1;
        bus.dc_rdata = (!bus.dc_wr && rq.size() != 0) ? rq.pop_front() : 32'hA5A5_A5A5;
        wait_cnt = 0;
      end else begin
        bus.dc_ack = 0;
        wait_cnt = bus.dc_req ? wait_cnt + 1 : 0;
      end
    end
  end
  initial begin
    forever begin
      @(negedge clk);
      if (rst && bus.dc_req && bus.dc_ack) begin
        checks++;
        if (exp_req.size() == 0) begin
          failures++;
          $display("FAIL unexpected_req got addr=%h size=%0d wr=%b, expected no request", bus.dc_addr, bus.dc_size, bus.dc_wr);
        end else begin
          me = exp_req.pop_front();
          mm = 0;
          for (int i = 0; i <= int'(me.size); i++) mm[8*i +: 8] = 8'hFF;
          if (bus.dc_addr !== me.addr || bus.dc_size !== me.size || bus.dc_wr !== me.wr ||
              (me.wr && (bus.dc_wdata & mm) !== (me.wdata & mm))) begin
            failures++;
            $display("FAIL dc_req got addr=%h size=%0d wr=%b wdata=%h, expected addr=%h size=%0d wr=%b wdata=%h",
                     bus.dc_addr, bus.dc_size, bus.dc_wr, bus.dc_wdata & mm, me.addr, me.size, me.wr, me.wdata & mm);
          end
        end
      end
      if (rst && bus.v_out) begin
        checks++;
        if (exp_out.size() == 0) begin
          failures++;
          $display("FAIL unexpected_v_out got v_out=1 rdata=%h, expected v_out=0", bus.rdata);
        end else begin
          mo = exp_out.pop_front();
          if (mo.chk && bus.rdata !== mo.rdata) begin
            failures++;
            $display("FAIL rdata got %h, expected %h", bus.rdata, mo.rdata);
          end
        end
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end
  task automatic drive_op(input logic rd, input logic wr, input logic [14:0] addr, input logic [1:0] sz,
                          input logic [31:0] wd, input int flush_at, output int cyc);
    int nb = int'(sz) + 1;
    @(posedge clk);
    #1;
    bus.v = 1; bus.rd = rd; bus.wr = wr; bus.cachable = 1; bus.phys_addr = addr;
    bus.req_size = sz; bus.spill = (int'(addr[3:0]) + nb > 16); bus.wdata = wd; bus.flush = 0;
    for (cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (!bus.stall) break;
      @(posedge clk);
      #1;
      bus.flush = (cyc + 1 == flush_at);
    end
    @(posedge clk);
    #1;
    bus.v = 0; bus.rd = 0; bus.wr = 0; bus.flush = 0;
  endtask
  task automatic test_reset();
    bus.v = 0; bus.rd = 0; bus.wr = 0; bus.cachable = 1; bus.phys_addr = 0;
    bus.req_size = 0; bus.spill = 0; bus.wdata = 0; bus.flush = 0;
    rst = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 5;
    if (bus.stall !== 1'b0) begin failures++; $display("FAIL reset_stall got %b, expected 0", bus.stall); end
    if (bus.dc_req !== 1'b0) begin failures++; $display("FAIL reset_dc_req got %b, expected 0", bus.dc_req); end
    if (bus.v_out !== 1'b0) begin failures++; $display("FAIL reset_v_out got %b, expected 0", bus.v_out); end
    if (bus.dc_wr !== 1'b0) begin failures++; $display("FAIL reset_dc_wr got %b, expected 0", bus.dc_wr); end
    if (bus.rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got %h, expected 0", bus.rdata); end
    @(posedge clk);
    #1;
    rst = 1;
  endtask
  task automatic test_load();
    int cyc;
    exp_req.push_back('{15'h0104, 2'd3, 1'b0, 32'h0});
    rq.push_back(32'h4433_2211);
    exp_out.push_back('{1'b1, 32'h4433_2211});
    drive_op(1, 0, 15'h0104, 2'd3, 32'h0, 0, cyc);
    checks++;
    if (cyc !== 3) begin failures++; $display("FAIL load_latency got %0d, expected 3", cyc); end
  endtask
  task automatic test_spill_load();
    int cyc;
    exp_req.push_back('{15'h000E, 2'd1, 1'b0, 32'h0});
    exp_req.push_back('{15'h0010, 2'd1, 1'b0, 32'h0});
    rq.push_back(32'h0000_BBAA);
    rq.push_back(32'h0000_DDCC);
    exp_out.push_back('{1'b1, 32'hDDCC_BBAA});
    drive_op(1, 0, 15'h000E, 2'd3, 32'h0, 0, cyc);
    checks++;
    if (cyc !== 4) begin failures++; $display("FAIL spill_load_latency got %0d, expected 4", cyc); end
  endtask
  task automatic test_spill_store();
    int cyc;
    exp_req.push_back('{15'h001F, 2'd0, 1'b1, 32'h34});
    exp_req.push_back('{15'h0020, 2'd0, 1'b1, 32'h12});
    exp_out.push_back('{1'b1, 32'h0});
    drive_op(0, 1, 15'h001F, 2'd1, 32'h1234, 0, cyc);
    checks++;
    if (cyc !== 4) begin failures++; $display("FAIL spill_store_latency got %0d, expected 4", cyc); end
  endtask
  task automatic test_ack_delay();
    int cyc;
    ack_delay = 3;
    exp_req.push_back('{15'h0230, 2'd1, 1'b0, 32'h0});
    rq.push_back(32'h0000_5566);
    exp_out.push_back('{1'b1, 32'h0000_5566});
    fork
      drive_op(1, 0, 15'h0230, 2'd1, 32'h0, 0, cyc);
      begin
        @(posedge clk);
        @(negedge clk);
        repeat (4) begin
          @(negedge clk);
          checks++;
          if (bus.dc_req !== 1'b1 || bus.dc_addr !== 15'h0230 || bus.dc_size !== 2'd1 || bus.stall !== 1'b1) begin
            failures++;
            $display("FAIL req_hold got req=%b addr=%h size=%0d stall=%b, expected req=1 addr=0230 size=1 stall=1",
                     bus.dc_req, bus.dc_addr, bus.dc_size, bus.stall);
          end
        end
      end
    join
    ack_delay = 0;
    checks++;
    if (cyc !== 6) begin failures++; $display("FAIL delay_latency got %0d, expected 6", cyc); end
  endtask
  task automatic test_flush_req1();
    int cyc;
    ack_delay = 2;
    exp_req.push_back('{15'h000E, 2'd1, 1'b0, 32'h0});
    rq.push_back(32'h0000_BBAA);
    drive_op(1, 0, 15'h000E, 2'd3, 32'h0, 2, cyc);
    ack_delay = 0;
    checks++;
    if (cyc !== 5) begin failures++; $display("FAIL flush_latency got %0d, expected 5", cyc); end
    @(negedge clk);
    checks++;
    if (bus.dc_req !== 1'b0 || bus.stall !== 1'b0 || bus.v_out !== 1'b0) begin
      failures++;
      $display("FAIL flush_idle got req=%b stall=%b v_out=%b, expected 0 0 0", bus.dc_req, bus.stall, bus.v_out);
    end
  endtask
  task automatic test_flush_done();
    int cyc;
    exp_req.push_back('{15'h0040, 2'd3, 1'b0, 32'h0});
    rq.push_back(32'h0BAD_F00D);
    drive_op(1, 0, 15'h0040, 2'd3, 32'h0, 3, cyc);
    checks++;
    if (cyc !== 3) begin failures++; $display("FAIL flush_done_latency got %0d, expected 3", cyc); end
  endtask
  task automatic test_passthrough();
    @(posedge clk);
    #1;
    bus.v = 1; bus.rd = 0; bus.wr = 0;
    exp_out.push_back('{1'b0, 32'h0});
    @(negedge clk);
    checks += 3;
    if (bus.v_out !== 1'b1) begin failures++; $display("FAIL pass_v_out got %b, expected 1", bus.v_out); end
    if (bus.stall !== 1'b0) begin failures++; $display("FAIL pass_stall got %b, expected 0", bus.stall); end
    if (bus.dc_req !== 1'b0) begin failures++; $display("FAIL pass_dc_req got %b, expected 0", bus.dc_req); end
    @(posedge clk);
    #1;
    bus.v = 0;
  endtask
  task automatic test_wrap();
    int cyc;
    exp_req.push_back('{15'h7FFE, 2'd1, 1'b0, 32'h0});
    exp_req.push_back('{15'h0000, 2'd1, 1'b0, 32'h0});
    rq.push_back(32'h0000_2211);
    rq.push_back(32'h0000_4433);
    exp_out.push_back('{1'b1, 32'h4433_2211});
    drive_op(1, 0, 15'h7FFE, 2'd3, 32'h0, 0, cyc);
    checks++;
    if (cyc !== 4) begin failures++; $display("FAIL wrap_latency got %0d, expected 4", cyc); end
  endtask
  task automatic test_mid_reset();
    ack_delay = 20;
    @(posedge clk);
    #1;
    bus.v = 1; bus.rd = 1; bus.wr = 0; bus.phys_addr = 15'h0100; bus.req_size = 2'd3; bus.spill = 0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.dc_req !== 1'b1 || bus.stall !== 1'b1) begin
      failures++;
      $display("FAIL midrst_pre got req=%b stall=%b, expected 1 1", bus.dc_req, bus.stall);
    end
    @(posedge clk);
    #1;
    rst = 0; bus.v = 0; bus.rd = 0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.dc_req !== 1'b0 || bus.stall !== 1'b0 || bus.v_out !== 1'b0) begin
      failures++;
      $display("FAIL midrst_post got req=%b stall=%b v_out=%b, expected 0 0 0", bus.dc_req, bus.stall, bus.v_out);
    end
    @(posedge clk);
    #1;
    rst = 1;
    ack_delay = 0;
  endtask
  task automatic test_back_to_back();
    logic [1:0]  sizes[3];
    logic [14:0] addr, a2;
    logic [1:0]  sz;
    logic [31:0] wd, w2, r1, r2, exp;
    logic [7:0]  b;
    logic        rd;
    int          nb, n1, n2, cyc;
    sizes = '{2'd0, 2'd1, 2'd3};
    for (int n = 0; n < 16; n++) begin
      rd = 1'($urandom_range(0, 1));
      sz = sizes[$urandom_range(0, 2)];
      addr = 15'($urandom_range(0, 32767));
      if (n % 3 == 0) addr[3:0] = 4'(13 + $urandom_range(0, 2));
      wd = $urandom;
      nb = int'(sz) + 1;
      n1 = 0;
      for (int i = 0; i < nb; i++) if (int'(addr[3:0]) + i < 16) n1++;
      n2 = nb - n1;
      exp_req.push_back('{addr, 2'(n1 - 1), !rd, wd});
      if (n2 > 0) begin
        a2 = {addr[14:4] + 11'd1, 4'd0};
        w2 = 0;
        for (int j = 0; j < n2; j++) w2[8*j +: 8] = wd[8*(n1+j) +: 8];
        exp_req.push_back('{a2, 2'(n2 - 1), !rd, w2});
      end
      r1 = $urandom;
      r2 = 0;
      exp = 0;
      for (int i = 0; i < nb; i++) begin
        b = 8'($urandom_range(0, 255));
        exp[8*i +: 8] = b;
        if (i < n1) r1[8*i +: 8] = b;
        else r2[8*(i-n1) +: 8] = b;
      end
      if (rd) begin
        rq.push_back(r1);
        if (n2 > 0) rq.push_back(r2);
      end
      exp_out.push_back('{1'b1, rd ? exp : 32'h0});
      drive_op(rd, !rd, addr, sz, wd, 0, cyc);
      checks++;
      if (cyc !== (n2 > 0 ? 4 : 3)) begin
        failures++;
        $display("FAIL b2b_latency op=%0d addr=%h got %0d, expected %0d", n, addr, cyc, n2 > 0 ? 4 : 3);
      end
    end
  endtask
  initial begin
    test_reset();
    test_load();
    test_spill_load();
    test_spill_store();
    test_ack_delay();
    test_flush_req1();
    test_flush_done();
    test_passthrough();
    test_wrap();
    test_mid_reset();
    test_back_to_back();
    repeat (3) @(posedge clk);
    checks++;
    if (exp_req.size() != 0 || exp_out.size() != 0) begin
      failures++;
      $display("FAIL drain got req_left=%0d out_left=%0d, expected 0 0", exp_req.size(), exp_out.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
